gray8_frame_reader: RTL and testbench

//  Frame-buffer reader and stream source for the 8-bit grayscale filter chain.
//  - Scans a 320x240 frame out of dual-bank BRAM in raster order.
//  - Drives the sink-side stream consumed by the 3x3 filters: pixel, pixel_addr, vsync, active_area, enable.
//  - Double-buffered: a bank swap requested by the frame writer is applied only at vertical-sync start.

---
 rtl/cam_video_pkg.sv | 38 +++
 rtl/video_timing_gen.sv | 69 ++++++
 rtl/gray8_frame_reader.sv | 133 +++++++++++++
 tb/tb_gray8_frame_reader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cam_video_pkg.sv
// Shared video timing, frame-buffer geometry and stream flag types for the grayscale chain.
package cam_video_pkg;

  localparam int unsigned HActive    = 320;
  localparam int unsigned HFp        = 8;
  localparam int unsigned HSync      = 48;
  localparam int unsigned HBp        = 24;
  localparam int unsigned HTotal     = HActive + HFp + HSync + HBp;
  localparam int unsigned HSyncStart = HActive + HFp;
  localparam int unsigned HSyncEnd   = HSyncStart + HSync;

  localparam int unsigned VActive    = 240;
  localparam int unsigned VFp        = 3;
  localparam int unsigned VSync      = 4;
  localparam int unsigned VBp        = 16;
  localparam int unsigned VTotal     = VActive + VFp + VSync + VBp;
  localparam int unsigned VSyncStart = VActive + VFp;
  localparam int unsigned VSyncEnd   = VSyncStart + VSync;

  localparam int unsigned FrameWords = 76800;
  localparam int unsigned PixW       = 8;
  localparam int unsigned PixAddrW   = 17;
  localparam int unsigned FbAddrW    = 18;
  localparam int unsigned HCntW      = 9;
  localparam int unsigned VCntW      = 9;

  typedef struct packed {
    logic act;
    logic hsync;
    logic vsync;
  } vid_flags_t;

  // Base address of a frame-buffer bank; bank 1 sits directly after bank 0.
  function automatic logic [FbAddrW-1:0] bank_base(input logic bank, input int unsigned words);
    bank_base = bank ? FbAddrW'(words) : '0;
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster h/v counters advancing on pixel ticks, with active/sync flags and frame strobes.
module video_timing_gen
  import cam_video_pkg::*;
#(
  parameter int unsigned HActivePix   = HActive,
  parameter int unsigned HFrontPorch  = HFp,
  parameter int unsigned HSyncLen     = HSync,
  parameter int unsigned HBackPorch   = HBp,
  parameter int unsigned VActiveLines = VActive,
  parameter int unsigned VFrontPorch  = VFp,
  parameter int unsigned VSyncLen     = VSync,
  parameter int unsigned VBackPorch   = VBp
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_ce,
  output vid_flags_t flags_o,
  output logic       swap_pt_o,
  output logic       frame_end_o
);

  localparam int unsigned HTot = HActivePix + HFrontPorch + HSyncLen + HBackPorch;
  localparam int unsigned VTot = VActiveLines + VFrontPorch + VSyncLen + VBackPorch;

  localparam logic [HCntW-1:0] HLast  = HCntW'(HTot - 1);
  localparam logic [HCntW-1:0] HAct   = HCntW'(HActivePix);
  localparam logic [HCntW-1:0] HSyncS = HCntW'(HActivePix + HFrontPorch);
  localparam logic [HCntW-1:0] HSyncE = HCntW'(HActivePix + HFrontPorch + HSyncLen);
  localparam logic [VCntW-1:0] VLast  = VCntW'(VTot - 1);
  localparam logic [VCntW-1:0] VAct   = VCntW'(VActiveLines);
  localparam logic [VCntW-1:0] VSyncS = VCntW'(VActiveLines + VFrontPorch);
  localparam logic [VCntW-1:0] VSyncE = VCntW'(VActiveLines + VFrontPorch + VSyncLen);

  logic [HCntW-1:0] h_cnt_q, h_cnt_d;
  logic [VCntW-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_ce) begin
      if (h_cnt_q == HLast) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    flags_o.act   = (h_cnt_q < HAct) && (v_cnt_q < VAct);
    flags_o.hsync = (h_cnt_q >= HSyncS) && (h_cnt_q < HSyncE);
    flags_o.vsync = (v_cnt_q >= VSyncS) && (v_cnt_q < VSyncE);
    // Start of vsync: the only place the display bank may change.
    swap_pt_o     = (h_cnt_q == '0) && (v_cnt_q == VSyncS);
    frame_end_o   = (h_cnt_q == HLast) && (v_cnt_q == VLast);
  end

endmodule

// File: rtl/gray8_frame_reader.sv
// Double-buffered frame-buffer reader: two-stage pipeline from raster counters to pixel stream.
module gray8_frame_reader
  import cam_video_pkg::*;
#(
  parameter int unsigned HActivePix   = HActive,
  parameter int unsigned HFrontPorch  = HFp,
  parameter int unsigned HSyncLen     = HSync,
  parameter int unsigned HBackPorch   = HBp,
  parameter int unsigned VActiveLines = VActive,
  parameter int unsigned VFrontPorch  = VFp,
  parameter int unsigned VSyncLen     = VSync,
  parameter int unsigned VBackPorch   = VBp,
  parameter int unsigned BankWords    = FrameWords
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pix_ce,
  input  logic                swap_req,
  output logic                swap_ack,
  output logic [FbAddrW-1:0]  fb_rd_addr,
  input  logic [PixW-1:0]     fb_rd_data,
  output logic [PixW-1:0]     pixel_out,
  output logic [PixAddrW-1:0] pixel_addr,
  output logic                active_area,
  output logic                hsync,
  output logic                vsync,
  output logic                enable
);

  vid_flags_t flags;
  logic       swap_pt, frame_end;

  video_timing_gen #(
    .HActivePix  (HActivePix),
    .HFrontPorch (HFrontPorch),
    .HSyncLen    (HSyncLen),
    .HBackPorch  (HBackPorch),
    .VActiveLines(VActiveLines),
    .VFrontPorch (VFrontPorch),
    .VSyncLen    (VSyncLen),
    .VBackPorch  (VBackPorch)
  ) u_timing (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_ce     (pix_ce),
    .flags_o    (flags),
    .swap_pt_o  (swap_pt),
    .frame_end_o(frame_end)
  );

  logic [PixAddrW-1:0] lin_q, lin_d, lin_a_q, lin_a_d, paddr_q, paddr_d;
  logic [FbAddrW-1:0]  rd_addr_q, rd_addr_d;
  logic [PixW-1:0]     pix_q, pix_d;
  vid_flags_t          flags_a_q, flags_a_d, flags_b_q, flags_b_d;
  logic                bank_q, bank_d, pend_q, pend_d, ack_q, ack_d;

  always_comb begin
    lin_d     = lin_q;
    rd_addr_d = rd_addr_q;
    lin_a_d   = lin_a_q;
    flags_a_d = flags_a_q;
    pix_d     = pix_q;
    paddr_d   = paddr_q;
    flags_b_d = flags_b_q;
    if (pix_ce) begin
      if (frame_end) begin
        lin_d = '0;
      end else if (flags.act) begin
        lin_d = lin_q + 1'b1;
      end
      // Reads only in the active area; the address holds otherwise.
      if (flags.act) begin
        rd_addr_d = bank_base(bank_q, BankWords) + FbAddrW'(lin_q);
      end
      lin_a_d   = lin_q;
      flags_a_d = flags;
      pix_d     = flags_a_q.act ? fb_rd_data : '0;
      paddr_d   = flags_a_q.act ? lin_a_q : '0;
      flags_b_d = flags_a_q;
    end
  end

  always_comb begin
    bank_d = bank_q;
    pend_d = pend_q;
    ack_d  = 1'b0;
    if (pix_ce && swap_pt) begin
      if (pend_q || swap_req) begin
        bank_d = ~bank_q;
        pend_d = 1'b0;
        ack_d  = 1'b1;
      end
    end else if (swap_req) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lin_q     <= '0;
      rd_addr_q <= '0;
      lin_a_q   <= '0;
      flags_a_q <= '0;
      pix_q     <= '0;
      paddr_q   <= '0;
      flags_b_q <= '0;
      bank_q    <= 1'b0;
      pend_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      lin_q     <= lin_d;
      rd_addr_q <= rd_addr_d;
      lin_a_q   <= lin_a_d;
      flags_a_q <= flags_a_d;
      pix_q     <= pix_d;
      paddr_q   <= paddr_d;
      flags_b_q <= flags_b_d;
      bank_q    <= bank_d;
      pend_q    <= pend_d;
      ack_q     <= ack_d;
    end
  end

  assign fb_rd_addr  = rd_addr_q;
  assign pixel_out   = pix_q;
  assign pixel_addr  = paddr_q;
  assign active_area = flags_b_q.act;
  assign hsync       = flags_b_q.hsync;
  assign vsync       = flags_b_q.vsync;
  assign swap_ack    = ack_q;
  assign enable      = pix_ce;

endmodule

// File: tb/tb_gray8_frame_reader.sv
// Directed bench for gray8_frame_reader on a reduced 15x8 raster (8x4 active, 32-word banks).
module tb_gray8_frame_reader;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2, HT = 15;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1, VT = 8;
  localparam int FW = 32;
  localparam int SwapV = VA + VF;

  logic        clk = 1'b0;
  logic        rst_n, pix_ce, swap_req, swap_ack, active_area, hsync, vsync, enable;
  logic [17:0] fb_rd_addr;
  logic [7:0]  fb_rd_data, pixel_out;
  logic [16:0] pixel_addr;

  int tests = 0, fails = 0;
  int tk, ack_pos, ack_seen, act_cnt, hs_cnt, vs_cnt;
  logic mbank, mpend, prev_bank;
  logic [17:0] m_fb;

  gray8_frame_reader #(
    .HActivePix(HA), .HFrontPorch(HF), .HSyncLen(HS), .HBackPorch(HB),
    .VActiveLines(VA), .VFrontPorch(VF), .VSyncLen(VS), .VBackPorch(VB),
    .BankWords(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .swap_req(swap_req), .swap_ack(swap_ack),
    .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data), .pixel_out(pixel_out),
    .pixel_addr(pixel_addr), .active_area(active_area), .hsync(hsync), .vsync(vsync),
    .enable(enable)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [17:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  always @(posedge clk) fb_rd_data <= memf(fb_rd_addr);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    tk = 0; mbank = 1'b0; mpend = 1'b0; prev_bank = 1'b0; m_fb = '0;
  endtask

  // One pixel tick after `idle` quiet clocks, checked against the raster model.
  task automatic step(input int idle, input logic req);
    int cur, h, v, ph, pv;
    logic cur_bank, exp_ack, pact, ehs, evs;
    logic [7:0] ep;
    logic [16:0] ea;
    logic [46:0] got, exp;
    repeat (idle) @(negedge clk);
    pix_ce = 1'b1; swap_req = req;
    #1;
    tests++;
    if (enable !== 1'b1) begin
      fails++; $display("FAIL enable: got %b required 1", enable);
    end
    @(negedge clk);
    pix_ce = 1'b0; swap_req = 1'b0;
    cur = tk; h = cur % HT; v = (cur / HT) % VT;
    cur_bank = mbank; exp_ack = 1'b0;
    if (h == 0 && v == SwapV) begin
      if (mpend || req) begin
        exp_ack = 1'b1; mbank = ~mbank; mpend = 1'b0;
      end
    end else if (req) mpend = 1'b1;
    if (h < HA && v < VA) m_fb = 18'(int'(cur_bank) * FW + v * HA + h);
    if (cur == 0) begin
      pact = 1'b0; ehs = 1'b0; evs = 1'b0; ea = '0; ep = '0;
    end else begin
      ph = (cur - 1) % HT; pv = ((cur - 1) / HT) % VT;
      pact = (ph < HA) && (pv < VA);
      ehs = (ph >= HA + HF) && (ph < HA + HF + HS);
      evs = (pv >= VA + VF) && (pv < VA + VF + VS);
      ea = pact ? 17'(pv * HA + ph) : '0;
      ep = pact ? memf(18'(int'(prev_bank) * FW + int'(ea))) : '0;
    end
    exp = {ep, ea, pact, ehs, evs, m_fb, exp_ack};
    got = {pixel_out, pixel_addr, active_area, hsync, vsync, fb_rd_addr, swap_ack};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL step tick=%0d got=%h required=%h", cur, got, exp);
    end
    if (active_area) act_cnt++;
    if (hsync) hs_cnt++;
    if (vsync) vs_cnt++;
    if (swap_ack) begin ack_seen++; ack_pos = cur; end
    prev_bank = cur_bank;
    tk++;
  endtask

  task automatic run_to(input int target);
    while (tk < target) step(1, 1'b0);
  endtask

  task automatic req_pulse();
    @(negedge clk); swap_req = 1'b1;
    @(negedge clk); swap_req = 1'b0;
    mpend = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pix_ce = 1'b0; swap_req = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if ({pixel_out, pixel_addr, active_area, hsync, vsync, fb_rd_addr, swap_ack, enable} !== '0) begin
      fails++; $display("FAIL reset_hold: got %h %h %b%b%b %h %b %b required all zero",
                        pixel_out, pixel_addr, active_area, hsync, vsync, fb_rd_addr, swap_ack, enable);
    end
    #3 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if ({pixel_out, pixel_addr, active_area, hsync, vsync, fb_rd_addr, swap_ack} !== '0) begin
      fails++; $display("FAIL reset_release_idle: got %h %h %h required all zero",
                        pixel_out, pixel_addr, fb_rd_addr);
    end
    model_reset();
  endtask

  task automatic test_frame();
    act_cnt = 0; hs_cnt = 0; vs_cnt = 0; ack_seen = 0;
    run_to(HT * VT + 1);
    tests++;
    if (act_cnt != HA * VA) begin
      fails++; $display("FAIL frame_active_ticks: got %0d required %0d", act_cnt, HA * VA);
    end
    tests++;
    if (hs_cnt != HS * VT) begin
      fails++; $display("FAIL frame_hsync_ticks: got %0d required %0d", hs_cnt, HS * VT);
    end
    tests++;
    if (vs_cnt != VS * HT) begin
      fails++; $display("FAIL frame_vsync_ticks: got %0d required %0d", vs_cnt, VS * HT);
    end
  endtask

  task automatic test_swap();
    run_to(120 + 2 * HT + 2);
    req_pulse();
    ack_seen = 0; ack_pos = -1;
    run_to(241);
    tests++;
    if (ack_seen != 1 || ack_pos != 120 + SwapV * HT) begin
      fails++; $display("FAIL swap_ack_point: got %0d acks at %0d required 1 at %0d",
                        ack_seen, ack_pos, 120 + SwapV * HT);
    end
    tests++;
    if (fb_rd_addr !== 18'(FW)) begin
      fails++; $display("FAIL swap_first_addr: got %0d required %0d", fb_rd_addr, FW);
    end
    ack_seen = 0;
    run_to(250); req_pulse();
    run_to(260); step(1, 1'b1);
    run_to(361);
    tests++;
    if (ack_seen != 1 || ack_pos != 240 + SwapV * HT) begin
      fails++; $display("FAIL swap_merge: got %0d acks at %0d required 1 at %0d",
                        ack_seen, ack_pos, 240 + SwapV * HT);
    end
    tests++;
    if (fb_rd_addr !== 18'd0) begin
      fails++; $display("FAIL swap_back_addr: got %0d required 0", fb_rd_addr);
    end
  endtask

  task automatic test_req_at_swap_point();
    run_to(360 + SwapV * HT);
    step(1, 1'b1);
    tests++;
    if (swap_ack !== 1'b1) begin
      fails++; $display("FAIL swap_same_clk: got %b required 1", swap_ack);
    end
    ack_seen = 0;
    run_to(480 + SwapV * HT + 1);
    tests++;
    if (ack_seen != 0) begin
      fails++; $display("FAIL swap_stale_pending: got %0d acks required 0", ack_seen);
    end
  endtask

  task automatic test_irregular();
    for (int i = 0; i < 130; i++) step(int'($urandom_range(1, 4)), 1'b0);
  endtask

  task automatic test_mid_reset();
    run_to(720 + 2 * HT + 4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({pixel_out, pixel_addr, active_area, hsync, vsync, fb_rd_addr, swap_ack} !== '0) begin
      fails++; $display("FAIL mid_reset_clear: got pix=%h addr=%h fb=%h required all zero",
                        pixel_out, pixel_addr, fb_rd_addr);
    end
    repeat (3) @(negedge clk);
    #4 rst_n = 1'b1;
    model_reset();
    step(1, 1'b0);
    step(1, 1'b0);
    tests++;
    if (pixel_addr !== 17'd0 || active_area !== 1'b1 || fb_rd_addr !== 18'd1) begin
      fails++; $display("FAIL mid_reset_restart: got addr=%0d act=%b fb=%0d required 0 1 1",
                        pixel_addr, active_area, fb_rd_addr);
    end
    run_to(40);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_swap();
    test_req_at_swap_point();
    test_irregular();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
